top_neurex: RTL and testbench

TOP_NEUREX -- requirements
Module: top_neurex

---
 rtl/top_neurex.sv | 111 +++++++++++
 tb/tb_top_neurex.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/top_neurex.sv
// top_neurex: buffered SYS_ROW x SYS_COL MAC array computing C = A * B,
// streaming one SYS_COL-wide result beat every num_common/SYS_ROW cycles.
module top_neurex #(
  parameter int SYS_ROW    = 4,
  parameter int SYS_COL    = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 16,
  parameter int ACCUM_SIZE = 32,
  parameter int PSUM_WIDTH = 2 * DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rstn,
  input  logic [DATA_WIDTH-1:0] num_in,
  input  logic [DATA_WIDTH-1:0] num_common,
  input  logic [DATA_WIDTH-1:0] num_out,
  input  logic                  in_en,
  input  logic                  w_en,
  input  logic [DATA_WIDTH-1:0] in_data [0:SYS_ROW-1],
  input  logic [DATA_WIDTH-1:0] w_data [0:SYS_COL-1],
  output logic [PSUM_WIDTH-1:0] out_wr_data [0:SYS_COL-1],
  output logic                  out_valid,
  output logic                  done
);
  localparam int AW = (ACCUM_SIZE > 1) ? $clog2(ACCUM_SIZE) : 1;
  localparam int CW = PSUM_WIDTH;
  localparam logic [CW-1:0] CAP = CW'(ACCUM_SIZE);
  localparam logic [CW-1:0] C1 = CW'(1);
  localparam logic [DATA_WIDTH-1:0] D1 = DATA_WIDTH'(1);
  typedef enum logic [1:0] {IDLE, LOAD, COMPUTE} state_t;
  state_t state_q, state_d;
  logic [DATA_WIDTH-1:0] a_buf [0:ACCUM_SIZE-1][0:SYS_ROW-1];
  logic [DATA_WIDTH-1:0] b_buf [0:ACCUM_SIZE-1][0:SYS_COL-1];
  logic [CW-1:0] a_cnt, b_cnt, a_total, b_total, a_idx;
  logic [CW-1:0] b_idx [0:SYS_ROW-1];
  logic [DATA_WIDTH-1:0] k_num, t_num, k_last, t_last, r_last, kk, tt, rr;
  logic [DATA_WIDTH-1:0] a_el [0:SYS_ROW-1];
  logic [PSUM_WIDTH-1:0] mac [0:SYS_COL-1];
  logic [PSUM_WIDTH-1:0] acc [0:SYS_COL-1];
  logic a_wr, b_wr, loaded, beat_end, job_end, busy;
  generate
    if (FIFO_DEPTH < 1 || ADDR_WIDTH < AW) begin : g_bad_cfg
      $error("top_neurex: FIFO_DEPTH must be >= 1 and ADDR_WIDTH must cover ACCUM_SIZE");
    end
  endgenerate
  // Zero dims clamp the last-index values so malformed jobs still terminate.
  always_comb begin
    k_num = num_common / DATA_WIDTH'(SYS_ROW);
    t_num = num_out / DATA_WIDTH'(SYS_COL);
    k_last = (k_num == '0) ? '0 : k_num - D1;
    t_last = (t_num == '0) ? '0 : t_num - D1;
    r_last = (num_in == '0) ? '0 : num_in - D1;
    a_total = CW'(num_in) * CW'(num_common) / CW'(SYS_ROW);
    b_total = CW'(num_common) * CW'(num_out) / CW'(SYS_COL);
    busy = state_q == COMPUTE;
    a_wr = in_en && !busy && a_cnt < a_total && a_cnt < CAP;
    b_wr = w_en && !busy && b_cnt < b_total && b_cnt < CAP;
    loaded = (a_cnt >= a_total || a_cnt >= CAP) && (b_cnt >= b_total || b_cnt >= CAP);
    beat_end = kk == k_last;
    job_end = busy && beat_end && rr == r_last && tt == t_last;
    state_d = (state_q == IDLE) ? ((in_en || w_en) ? LOAD : IDLE) :
              (state_q == LOAD) ? (loaded ? COMPUTE : LOAD) :
              (job_end ? IDLE : COMPUTE);
  end
  // A chunk kk of row rr against B rows kk*SYS_ROW.. of column tile tt.
  always_comb begin
    a_idx = CW'(rr) * CW'(k_num) + CW'(kk);
    for (int i = 0; i < SYS_ROW; i++) begin
      b_idx[i] = (CW'(kk) * CW'(SYS_ROW) + CW'(i)) * CW'(t_num) + CW'(tt);
      a_el[i] = (a_idx < CAP) ? a_buf[a_idx[AW-1:0]][i] : '0;
    end
    for (int k = 0; k < SYS_COL; k++) begin
      mac[k] = '0;
      for (int i = 0; i < SYS_ROW; i++)
        mac[k] = mac[k] + ((b_idx[i] < CAP) ? CW'(a_el[i]) * CW'(b_buf[b_idx[i][AW-1:0]][k]) : '0);
    end
  end
  always_ff @(posedge clk) begin
    if (a_wr) a_buf[a_cnt[AW-1:0]] <= in_data;
    if (b_wr) b_buf[b_cnt[AW-1:0]] <= w_data;
  end
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      state_q <= IDLE;
      a_cnt <= '0;
      b_cnt <= '0;
      kk <= '0;
      tt <= '0;
      rr <= '0;
      out_valid <= 1'b0;
      done <= 1'b0;
      for (int k = 0; k < SYS_COL; k++) begin
        acc[k] <= '0;
        out_wr_data[k] <= '0;
      end
    end else begin
      state_q <= state_d;
      a_cnt <= job_end ? '0 : a_wr ? a_cnt + C1 : a_cnt;
      b_cnt <= job_end ? '0 : b_wr ? b_cnt + C1 : b_cnt;
      out_valid <= busy && beat_end;
      done <= job_end;
      kk <= (!busy || beat_end) ? '0 : kk + D1;
      tt <= !busy ? '0 : beat_end ? ((tt == t_last) ? '0 : tt + D1) : tt;
      rr <= !busy ? '0 : (beat_end && tt == t_last) ? rr + D1 : rr;
      for (int k = 0; k < SYS_COL; k++) begin
        acc[k] <= (!busy || beat_end) ? '0 : acc[k] + mac[k];
        if (busy && beat_end) out_wr_data[k] <= acc[k] + mac[k];
      end
    end
  end
endmodule

// File: tb/tb_top_neurex.sv
// tb_top_neurex: scoreboard bench for top_neurex; stimulus pushes expected
// beats (data, done, arrival cycle) and a negedge monitor pops and compares.
module tb_top_neurex;
  logic clk = 0;
  logic rstn = 1;
  logic [15:0] num_in = 0, num_common = 0, num_out = 0;
  logic in_en = 0, w_en = 0;
  logic [15:0] in_data [0:3];
  logic [15:0] w_data [0:3];
  logic [31:0] out_wr_data [0:3];
  logic out_valid, done;
  logic [31:0] cyc = 0;
  logic [31:0] c0;
  int n_vec = 0, n_fail = 0, beat_no = 0;
  typedef struct packed {
    logic [3:0][31:0] d;
    logic dn;
    logic [31:0] cyc;
  } exp_t;
  exp_t q[$];
  exp_t mon_e;

  top_neurex dut (
    .clk(clk), .rstn(rstn), .num_in(num_in), .num_common(num_common), .num_out(num_out),
    .in_en(in_en), .w_en(w_en), .in_data(in_data), .w_data(w_data),
    .out_wr_data(out_wr_data), .out_valid(out_valid), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (out_valid) begin
      check($sformatf("beat_expected %0d", beat_no), 64'(q.size() != 0), 1);
      if (q.size() != 0) begin
        mon_e = q.pop_front();
        for (int k = 0; k < 4; k++)
          check($sformatf("data[%0d] beat %0d", k, beat_no), 64'(out_wr_data[k]), 64'(mon_e.d[k]));
        check($sformatf("done beat %0d", beat_no), 64'(done), 64'(mon_e.dn));
        check($sformatf("cycle beat %0d", beat_no), 64'(cyc), 64'(mon_e.cyc));
      end
      beat_no++;
    end else if (done) begin
      check("done_without_valid", 64'(done), 0);
    end
  end

  task automatic job_8816(input bit extra);
    exp_t e;
    num_in = 8; num_common = 8; num_out = 16;
    for (int c = 0; c < 32; c++) begin
      in_en = (c < 16) || extra;
      w_en = 1;
      for (int j = 0; j < 4; j++) begin
        in_data[j] = (c >= 16) ? 16'hBEEF : 16'((c % 2) * 4 + j + 1);
        w_data[j] = 16'(c + j);
      end
      @(posedge clk); #1;
    end
    c0 = cyc;
    for (int r = 0; r < 8; r++)
      for (int t = 0; t < 4; t++) begin
        for (int j = 0; j < 4; j++) e.d[j] = 32'(672 + 36 * (t + j));
        e.dn = (r == 7) && (t == 3);
        e.cyc = c0 + 32'((r * 4 + t + 1) * 2 + 1);
        q.push_back(e);
      end
    in_en = extra; w_en = extra;
    for (int j = 0; j < 4; j++) begin
      in_data[j] = 16'h7777;
      w_data[j] = 16'h5555;
    end
    if (extra) begin
      repeat (20) @(posedge clk);
      #1;
    end
    in_en = 0; w_en = 0;
  endtask

  task automatic job_444();
    exp_t e;
    num_in = 4; num_common = 4; num_out = 4;
    in_en = 1; w_en = 1;
    for (int j = 0; j < 4; j++) begin
      in_data[j] = 16'hFFFF;
      w_data[j] = 16'hFFFF;
    end
    repeat (4) @(posedge clk);
    #1;
    c0 = cyc;
    in_en = 0; w_en = 0;
    for (int n = 0; n < 4; n++) begin
      for (int j = 0; j < 4; j++) e.d[j] = 32'hFFF80004;
      e.dn = (n == 3);
      e.cyc = c0 + 32'(n + 2);
      q.push_back(e);
    end
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 300 && q.size() != 0; i++) @(negedge clk);
    check({name, "_drain"}, 64'(q.size()), 0);
    @(posedge clk); #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_valid"}, 64'(out_valid), 0);
    check({name, "_done"}, 64'(done), 0);
    for (int k = 0; k < 4; k++) check($sformatf("%s_data[%0d]", name, k), 64'(out_wr_data[k]), 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    for (int j = 0; j < 4; j++) begin
      in_data[j] = 0;
      w_data[j] = 0;
    end
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    rstn = 0;
    @(posedge clk); #1;
    job_8816(0);
    drain("job1");
    job_8816(1);
    drain("extra");
    job_8816(0);
    drain("back_to_back");
    job_444();
    drain("saturate");
    job_8816(0);
    repeat (10) @(posedge clk);
    #1;
    rstn = 1;
    q.delete();
    #1;
    check_idle_outputs("abort");
    @(posedge clk); #1;
    rstn = 0;
    repeat (80) @(posedge clk);
    #1;
    job_8816(0);
    drain("after_abort");
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end
endmodule
